// File: rtl/ahfp_pkg.sv
// Shared constants for the ahfp multiplier blocks: FSM state encoding,
// IEEE-754 single-precision field positions and the default multiplier latency.
package ahfp_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    localparam int MUL_LATENCY_DEF = 3;

endpackage

// File: rtl/ahfp_mul_ci_ctrl_if.sv
// Nios II multi-cycle custom-instruction port between the CPU (master)
// and the multiplier front end (slave).
interface ahfp_mul_ci_ctrl_if;

    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;
    logic        busy;

    modport master (
        output clk_en, start, dataa, datab,
        input  done, result, busy
    );

    modport slave (
        input  clk_en, start, dataa, datab,
        output done, result, busy
    );

endinterface

// File: rtl/ahfp_mul_multi.sv
// Pipelined IEEE-754 single-precision multiplier: round-to-nearest-even,
// denormals flushed to zero, no reset and no enable (free-running pipeline).
module ahfp_mul_multi
    import ahfp_pkg::*;
#(
    parameter int LATENCY = MUL_LATENCY_DEF
) (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] p
);

    function automatic logic [31:0] fp_round_pack(
        input logic               sign,
        input logic signed [10:0] exp_in,
        input logic [23:0]        man,
        input logic               guard,
        input logic               sticky
    );
        logic [24:0]        rnd;
        logic signed [10:0] e;
        rnd = {1'b0, man} + {24'd0, guard & (sticky | man[0])};
        e   = exp_in;
        // Rounding carry out of the hidden bit renormalises to 1.000...
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 11'sd1;
        end
        if (e >= 11'sd255) begin
            return {sign, 8'hFF, 23'd0};
        end else if (e <= 11'sd0) begin
            return {sign, 31'd0};
        end
        return {sign, e[7:0], rnd[MAN_MSB:0]};
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
        logic               sign;
        logic [7:0]         ex, ey;
        logic               nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
        logic [47:0]        prod;
        logic signed [10:0] e;
        sign   = x[SIGN_BIT] ^ y[SIGN_BIT];
        ex     = x[EXP_MSB:EXP_LSB];
        ey     = y[EXP_MSB:EXP_LSB];
        nan_x  = (ex == 8'hFF) && (x[MAN_MSB:0] != '0);
        nan_y  = (ey == 8'hFF) && (y[MAN_MSB:0] != '0);
        inf_x  = (ex == 8'hFF) && (x[MAN_MSB:0] == '0);
        inf_y  = (ey == 8'hFF) && (y[MAN_MSB:0] == '0);
        zero_x = (ex == 8'h00);
        zero_y = (ey == 8'h00);
        if (nan_x || nan_y || (inf_x && zero_y) || (zero_x && inf_y)) begin
            return 32'h7FC0_0000;
        end else if (inf_x || inf_y) begin
            return {sign, 8'hFF, 23'd0};
        end else if (zero_x || zero_y) begin
            return {sign, 31'd0};
        end
        prod = {24'd0, 1'b1, x[MAN_MSB:0]} * {24'd0, 1'b1, y[MAN_MSB:0]};
        e    = $signed({3'b000, ex}) + $signed({3'b000, ey}) - 11'sd127;
        if (prod[47]) begin
            return fp_round_pack(sign, e + 11'sd1, prod[47:24], prod[23], |prod[22:0]);
        end
        return fp_round_pack(sign, e, prod[46:23], prod[22], |prod[21:0]);
    endfunction

    logic [31:0] prod_p [LATENCY];

    // Stage p0 holds the rounded product; later stages only add delay.
    always_ff @(posedge clk) begin
        prod_p[0] <= fp_mul(a, b);
        for (int i = 1; i < LATENCY; i++) begin
            prod_p[i] <= prod_p[i-1];
        end
    end

    assign p = prod_p[LATENCY-1];

endmodule

// File: rtl/ahfp_mul_ci_ctrl.sv
// Multi-cycle custom-instruction front end for ahfp_mul_multi. Define
// AHFP_ZERO_BYPASS_EN to finish zero/denormal operands in one cycle.
module ahfp_mul_ci_ctrl
    import ahfp_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    ahfp_mul_ci_ctrl_if.slave ci
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      opa;
    logic [31:0]      opb;
    logic [31:0]      res;
    logic [31:0]      mul_out;
    logic             zero_op;

`ifdef AHFP_ZERO_BYPASS_EN
    assign zero_op = (ci.dataa[EXP_MSB:EXP_LSB] == 8'd0) || (ci.datab[EXP_MSB:EXP_LSB] == 8'd0);
`else
    assign zero_op = 1'b0;
`endif

    // Operand registers feed the multiplier directly and stay put through
    // stalls, so its output is still valid whenever clk_en returns.
    ahfp_mul_multi #(
        .LATENCY(MUL_LATENCY)
    ) u_mul (
        .clk(clk),
        .a  (opa),
        .b  (opb),
        .p  (mul_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
        end else if (ci.clk_en) begin
            case (state)
                IDLE: begin
                    if (ci.start) begin
                        opa <= ci.dataa;
                        opb <= ci.datab;
                        cnt <= '0;
                        if (zero_op) begin
                            res   <= {ci.dataa[SIGN_BIT] ^ ci.datab[SIGN_BIT], 31'd0};
                            state <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        res   <= mul_out;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ci.done   = (state == DONE);
    assign ci.busy   = (state != IDLE);
    assign ci.result = res;

endmodule

// File: tb/tb_ahfp_mul_ci_ctrl.sv
// Randomized self-checking bench for ahfp_mul_ci_ctrl with a real-arithmetic
// reference multiplier and cycle-count latency model.
module tb_ahfp_mul_ci_ctrl;
    import ahfp_pkg::*;

    localparam int L = MUL_LATENCY_DEF;
`ifdef AHFP_ZERO_BYPASS_EN
    localparam bit ZBYP = 1'b1;
`else
    localparam bit ZBYP = 1'b0;
`endif

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    ahfp_mul_ci_ctrl_if ci_if ();

    ahfp_mul_ci_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .ci   (ci_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Exact product in double precision, then round-to-nearest-even to 24 bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     ea, eb, k, e;
        real    pr, q, fl;
        longint m;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 0 || eb == 0) return {s, 31'd0};
        pr = real'({1'b1, a[22:0]}) * real'({1'b1, b[22:0]});
        k  = (pr >= 2.0 ** 47) ? 24 : 23;
        q  = pr / (2.0 ** k);
        fl = $floor(q);
        m  = longint'(fl);
        if ((q - fl > 0.5) || ((q - fl == 0.5) && m[0])) m++;
        if (m == (longint'(1) << 24)) begin
            m = m >>> 1;
            k++;
        end
        e = ea + eb + k - 150;
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [7:0] e;
        e = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    // Issue one operation and follow it to done; a stall of stall_len cycles
    // is inserted once stall_at enabled edges have passed after the accept.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                          input bit zero_path, input int stall_at, input int stall_len, input bit spur);
        int need, n_en, stalled, cyc;
        need    = zero_path ? 0 : L + 1;
        n_en    = 0;
        stalled = 0;
        ci_if.start  = 1'b1;
        ci_if.clk_en = 1'b1;
        ci_if.dataa  = a;
        ci_if.datab  = b;
        @(posedge clk) #1;
        ci_if.start = 1'b0;
        ci_if.dataa = $urandom;
        ci_if.datab = $urandom;
        for (cyc = 0; cyc < need + stall_len + 4; cyc++) begin
            check("done", 32'(ci_if.done), 32'(n_en == need));
            check("busy", 32'(ci_if.busy), 32'd1);
            if (n_en == need) break;
            if (n_en == stall_at && stalled < stall_len) begin
                ci_if.clk_en = 1'b0;
                stalled++;
            end else begin
                ci_if.clk_en = 1'b1;
            end
            ci_if.start = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            ci_if.dataa = $urandom;
            ci_if.datab = $urandom;
            @(posedge clk) #1;
            if (ci_if.clk_en) n_en++;
        end
        check("latency", 32'(cyc), 32'(need + ((stall_at < need) ? stall_len : 0)));
        check("result", ci_if.result, exp_res);
        ci_if.start  = 1'b0;
        ci_if.clk_en = 1'b1;
        @(posedge clk) #1;
        check("done_drop", 32'(ci_if.done), 32'd0);
        check("busy_drop", 32'(ci_if.busy), 32'd0);
        check("result_hold", ci_if.result, exp_res);
    endtask

    initial begin
        logic [31:0] a, b;
        n_chk = 0;
        n_err = 0;
        reset        = 1'b1;
        ci_if.clk_en = 1'b1;
        ci_if.start  = 1'b1;
        ci_if.dataa  = 32'h3F80_0000;
        ci_if.datab  = 32'h4000_0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(ci_if.done), 32'd0);
        check("rst_busy", 32'(ci_if.busy), 32'd0);
        check("rst_result", ci_if.result, 32'd0);
        ci_if.start = 1'b0;
        reset = 1'b0;
        @(posedge clk) #1;

        run_op(32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0, 99, 0, 1'b0);
        run_op(32'h4040_0000, 32'h4060_0000, 32'h4128_0000, 1'b0, 99, 0, 1'b0);
        run_op(32'h3F8E_363B, 32'h3AA1_37F4, 32'h3AB3_1E61, 1'b0, 99, 0, 1'b0);
        run_op(32'h43FA_0000, 32'h4113_3333, 32'h458F_C000, 1'b0, 1, 3, 1'b0);
        run_op(32'h46A5_E51F, 32'h435F_AB85, 32'h4A90_F1BC, 1'b0, 99, 0, 1'b1);

        // Abort an operation with reset two cycles into WAIT.
        ci_if.start = 1'b1;
        ci_if.dataa = 32'h4040_0000;
        ci_if.datab = 32'h4060_0000;
        @(posedge clk) #1;
        ci_if.start = 1'b0;
        @(posedge clk) #2;
        reset = 1'b1;
        #1;
        check("abort_done", 32'(ci_if.done), 32'd0);
        check("abort_busy", 32'(ci_if.busy), 32'd0);
        check("abort_result", ci_if.result, 32'd0);
        @(posedge clk) #1;
        reset = 1'b0;
        for (int i = 0; i < L + 4; i++) begin
            @(posedge clk) #1;
            check("abort_nodone", 32'(ci_if.done), 32'd0);
        end
        run_op(32'h4640_E400, 32'h47F1_2040, 32'h4EB5_AEF1, 1'b0, 99, 0, 1'b0);

        run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, ZBYP, 99, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            a = rand_operand();
            b = rand_operand();
            run_op(a, b, ref_mul(a, b), ZBYP && (a[30:23] == 8'd0 || b[30:23] == 8'd0),
                   $urandom_range(0, L), $urandom_range(0, 3), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
